// File: rtl/inst_mem_resp.sv
// Instruction memory responder with a fixed response latency.
// An accepted request reads the internal word array immediately, formats the
// word/halfword/byte result, and presents it LATENCY cycles later as a
// one-cycle i_read_valid pulse. A separate loader port writes the array.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_read_req      one-cycle request pulse
//   i_read_w        word access
//   i_read_hw       halfword access (when i_read_w=0); byte when both 0
//   i_read_adr      byte address of request
//   i_read_valid    one-cycle response pulse
//   i_read_data     response data, held until the next response
//   busy            request accepted, response pending
//   ld_we/adr/data  program-load write port (word addressed)
//   err_clr         clears the sticky error flags
//   err_ovr         sticky: request arrived while busy
//   err_range       sticky: accepted request was outside the array
module inst_mem_resp #(
    parameter int unsigned ADR_WIDTH = 12,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_read_req,
    input  logic                 i_read_w,
    input  logic                 i_read_hw,
    input  logic [31:0]          i_read_adr,
    output logic                 i_read_valid,
    output logic [31:0]          i_read_data,
    output logic                 busy,
    input  logic                 ld_we,
    input  logic [ADR_WIDTH-1:0] ld_adr,
    input  logic [31:0]          ld_data,
    input  logic                 err_clr,
    output logic                 err_ovr,
    output logic                 err_range
);

    localparam int unsigned DEPTH    = 1 << ADR_WIDTH;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned HI_SHIFT = ADR_WIDTH + 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [31:0]      NOP_INSN = 32'h0000_0013;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    logic [31:0]          mem [DEPTH];
    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 accept_c;
    logic                 ovr_set_c;
    logic                 valid_nxt;
    logic [31:0]          resp_q;
    logic [ADR_WIDTH-1:0] rd_idx_c;
    logic                 oor_c;
    logic [31:0]          fmt_c;

    assign rd_idx_c = i_read_adr[ADR_WIDTH+1:2];
    assign oor_c    = (i_read_adr >> HI_SHIFT) != 32'd0;

    // Size/lane selection of the word read this cycle, zero-extended.
    always_comb begin
        logic [31:0] word;
        word = mem[rd_idx_c];
        if (oor_c) begin
            fmt_c = NOP_INSN;
        end else if (i_read_w) begin
            fmt_c = word;
        end else if (i_read_hw) begin
            fmt_c = i_read_adr[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
        end else begin
            case (i_read_adr[1:0])
                2'd0:    fmt_c = {24'h0, word[7:0]};
                2'd1:    fmt_c = {24'h0, word[15:8]};
                2'd2:    fmt_c = {24'h0, word[23:16]};
                default: fmt_c = {24'h0, word[31:24]};
            endcase
        end
    end

    // Program-load port; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && ld_we) begin
            mem[ld_adr] <= ld_data;
        end
    end

    // Next state: the valid cycle itself is spent in IDLE so a new request
    // can be taken there, giving one response per LATENCY cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept_c  = 1'b0;
        ovr_set_c = 1'b0;
        valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (i_read_req) begin
                    accept_c = 1'b1;
                    cnt_nxt  = CNT_LOAD;
                    if (CNT_LOAD == '0) begin
                        valid_nxt = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                ovr_set_c = i_read_req;
                cnt_nxt   = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    valid_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            i_read_valid <= 1'b0;
            busy         <= 1'b0;
            i_read_data  <= '0;
            resp_q       <= '0;
            err_ovr      <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            i_read_valid <= valid_nxt;
            busy         <= (state_nxt == BUSY);
            if (accept_c) begin
                resp_q <= fmt_c;
            end
            if (valid_nxt) begin
                i_read_data <= accept_c ? fmt_c : resp_q;
            end
            // Set wins over a simultaneous clear.
            err_ovr   <= ovr_set_c | (err_ovr & ~err_clr);
            err_range <= (accept_c & oor_c) | (err_range & ~err_clr);
        end
    end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Scoreboard bench for inst_mem_resp (ADR_WIDTH=12, LATENCY=2).
module tb_inst_mem_resp;

    localparam int unsigned AW  = 12;
    localparam int unsigned LAT = 2;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read_req;
    logic          i_read_w;
    logic          i_read_hw;
    logic [31:0]   i_read_adr;
    logic          i_read_valid;
    logic [31:0]   i_read_data;
    logic          busy;
    logic          ld_we;
    logic [AW-1:0] ld_adr;
    logic [31:0]   ld_data;
    logic          err_clr;
    logic          err_ovr;
    logic          err_range;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];

    inst_mem_resp #(.ADR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read_req   (i_read_req),
        .i_read_w     (i_read_w),
        .i_read_hw    (i_read_hw),
        .i_read_adr   (i_read_adr),
        .i_read_valid (i_read_valid),
        .i_read_data  (i_read_data),
        .busy         (busy),
        .ld_we        (ld_we),
        .ld_adr       (ld_adr),
        .ld_data      (ld_data),
        .err_clr      (err_clr),
        .err_ovr      (err_ovr),
        .err_range    (err_range)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (i_read_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got data %h at cycle %0d, expected no response", i_read_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_data", i_read_data, e.data);
                check("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic idle_inputs();
        i_read_req = 1'b0; i_read_w = 1'b0; i_read_hw = 1'b0; i_read_adr = '0;
        ld_we = 1'b0; ld_adr = '0; ld_data = '0; err_clr = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_adr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    // Drives a request for the current cycle; records expectation if accepted.
    task automatic drive_req(input logic [31:0] a, input logic w, input logic hw,
                             input logic [31:0] exp_d, input logic expect_resp);
        exp_t e;
        i_read_req = 1'b1; i_read_adr = a; i_read_w = w; i_read_hw = hw;
        if (expect_resp) begin
            e.data = exp_d;
            e.cyc  = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic one_req(input logic [31:0] a, input logic w, input logic hw, input logic [31:0] exp_d);
        drive_req(a, w, hw, exp_d, 1'b1);
        tick();
        i_read_req = 1'b0;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(i_read_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", i_read_data, 0);
        check("rst_ovr", 32'(err_ovr), 0);
        check("rst_range", 32'(err_range), 0);
        rst_n = 1'b1;
        tick();

        load(12'd5, 32'h1234_5678);
        load(12'd7, 32'h0BAD_F00D);
        load(12'd4095, 32'hCAFE_0001);

        // Word read with busy during the wait cycle.
        drive_req(32'h14, 1'b1, 1'b0, 32'h1234_5678, 1'b1);
        tick();
        i_read_req = 1'b0;
        check("busy_t1", 32'(busy), 1);
        tick();
        check("busy_valid_cycle", 32'(busy), 0);
        tick();
        check("data_hold", i_read_data, 32'h1234_5678);
        check("busy_after", 32'(busy), 0);

        // Back-to-back sub-word reads, each issued in the previous valid cycle.
        one_req(32'h16, 1'b0, 1'b1, 32'h0000_1234);
        one_req(32'h17, 1'b0, 1'b0, 32'h0000_0012);
        one_req(32'h15, 1'b0, 1'b0, 32'h0000_0056);
        one_req(32'h14, 1'b0, 1'b1, 32'h0000_5678);
        one_req(32'h3FFC, 1'b1, 1'b0, 32'hCAFE_0001);
        check("no_range_err", 32'(err_range), 0);
        tick(); tick();

        // Overrun: second request ignored, third accepted in valid cycle.
        drive_req(32'h14, 1'b1, 1'b0, 32'h1234_5678, 1'b1);
        tick();
        drive_req(32'h17, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check("ovr_set", 32'(err_ovr), 1);
        drive_req(32'h16, 1'b0, 1'b1, 32'h0000_1234, 1'b1);
        tick();
        i_read_req = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovr_cleared", 32'(err_ovr), 0);
        tick();

        // Set and clear in the same cycle: set wins.
        drive_req(32'h14, 1'b1, 1'b0, 32'h1234_5678, 1'b1);
        tick();
        drive_req(32'h14, 1'b1, 1'b0, 32'h0, 1'b0);
        err_clr = 1'b1;
        tick();
        i_read_req = 1'b0;
        err_clr = 1'b0;
        check("ovr_set_wins", 32'(err_ovr), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();

        // Out-of-range addresses return NOP and set err_range.
        one_req(32'h0001_0000, 1'b0, 1'b0, 32'h0000_0013);
        check("range_set", 32'(err_range), 1);
        one_req(32'h0000_4000, 1'b1, 1'b0, 32'h0000_0013);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("range_cleared", 32'(err_range), 0);

        // Read-before-write on the acceptance cycle.
        drive_req(32'h14, 1'b1, 1'b0, 32'h1234_5678, 1'b1);
        ld_we = 1'b1; ld_adr = 12'd5; ld_data = 32'hDEAD_BEEF;
        tick();
        i_read_req = 1'b0; ld_we = 1'b0;
        tick();
        one_req(32'h14, 1'b1, 1'b0, 32'hDEAD_BEEF);
        tick();

        // Reset mid-busy aborts the response; loads ignored during reset.
        drive_req(32'h1C, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        i_read_req = 1'b0;
        rst_n = 1'b0;
        ld_we = 1'b1; ld_adr = 12'd7; ld_data = 32'hFFFF_FFFF;
        tick();
        ld_we = 1'b0;
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 0);
        check("abort_data", i_read_data, 0);
        tick(); tick();
        one_req(32'h1C, 1'b1, 1'b0, 32'h0BAD_F00D);
        tick();

        // Bounded drain of any outstanding expectations.
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_resp.md
INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 Parameter ADR_WIDTH, default 12, word-address width of internal instruction array (2^ADR_WIDTH 32-bit words).
REQ-002 Parameter LATENCY, default 2, cycles from accepted request to i_read_valid; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_read_req  input  1  one-cycle request pulse from instruction-read initiator.
REQ-006 i_read_w  input  1  word access when 1.
REQ-007 i_read_hw  input  1  halfword access when 1 and i_read_w=0; byte access when both 0.
REQ-008 i_read_adr  input  32  byte address of request.
REQ-009 i_read_valid  output  1  one-cycle pulse, response data valid.
REQ-010 i_read_data  output  32  response data.
REQ-011 busy  output  1  request accepted, response pending.
REQ-012 ld_we  input  1  program-load write strobe from monitor/loader.
REQ-013 ld_adr  input  ADR_WIDTH  program-load word address.
REQ-014 ld_data  input  32  program-load write data.
REQ-015 err_clr  input  1  clears sticky error flags.
REQ-016 err_ovr  output  1  sticky: request received while busy.
REQ-017 err_range  output  1  sticky: out-of-range address requested.

Function
REQ-018 FSM states IDLE and BUSY only; IDLE after reset.
REQ-019 IDLE with i_read_req=1 in cycle T: capture i_read_adr, i_read_w, i_read_hw, read array at i_read_adr[ADR_WIDTH+1:2], enter BUSY, busy=1 from T+1.
REQ-020 i_read_valid SHALL be 1 exactly in cycle T+LATENCY and 0 otherwise; FSM returns to IDLE in that same cycle, busy=0 in T+LATENCY.
REQ-021 Wait counter 4 bits, loaded LATENCY-1 at acceptance, decremented each BUSY cycle, response issued at count 0; LATENCY=1 gives valid in T+1.
REQ-022 Request in cycle T+LATENCY (valid cycle) SHALL be accepted as new IDLE request; back-to-back throughput one response per LATENCY cycles.
REQ-023 i_read_req while BUSY (excluding valid cycle) SHALL be ignored, not queued, set err_ovr; pending response unaffected.
REQ-024 Accepted request SHALL always complete with valid regardless of later i_read_req/initiator stall activity.
REQ-025 Word access: i_read_data = array word, i_read_adr[1:0] ignored.
REQ-026 Halfword access: little-endian halfword selected by adr[1] (0=bits 15:0, 1=bits 31:16), zero-extended; adr[0] ignored.
REQ-027 Byte access: byte selected by adr[1:0] (0=bits 7:0 ... 3=bits 31:24), zero-extended.
REQ-028 Address with any of i_read_adr[31:ADR_WIDTH+2] nonzero: response data 32'h0000_0013 (NOP) regardless of size, same latency, err_range set.
REQ-029 Array read at acceptance cycle T is read-before-write: ld_we to same word in cycle T or later does not alter that response.
REQ-030 ld_we writes ld_data to array at ld_adr in any state; no effect on FSM.
REQ-031 i_read_data updated only in valid cycle; holds value until next valid.
REQ-032 err_clr=1 clears both flags; setting event in same cycle as err_clr wins (flag set).

Reset
REQ-033 rst_n=0 at rising edge: state IDLE, counter 0, i_read_valid=0, busy=0, i_read_data=0, err_ovr=0, err_range=0.
REQ-034 Reset mid-BUSY SHALL abort pending response; no i_read_valid issued afterwards for it.
REQ-035 Array contents not reset; ld_we ignored while rst_n=0.

Verification
REQ-036 LATENCY=2, load word 5=32'h1234_5678, req adr 32'h14 w=1 at T -> valid only at T+2, data 32'h1234_5678, busy=1 at T+1.
REQ-037 Same word, req adr 32'h16 hw=1 -> 32'h0000_1234; adr 32'h17 byte -> 32'h0000_0012.
REQ-038 Req at T, second req at T+1 -> single valid at T+2, err_ovr=1; err_clr -> 0; req at T+2 -> accepted, valid at T+4.
REQ-039 ADR_WIDTH=12, req adr 32'h0001_0000 -> data 32'h0000_0013 at T+LATENCY, err_range=1.
REQ-040 Req at T, ld_we same word at T with 32'hDEAD_BEEF -> old data returned; next req returns 32'hDEAD_BEEF.
REQ-041 Req at T, rst_n=0 at T+1 -> no valid at T+2, busy=0, i_read_data=0.
